mbu_ctx_seq: RTL
================

Name: mbu_ctx_seq

Overview:
Bank-map context sequencer for the Memory Bank Unit. Holds NCTX shadow copies of the eight 8-bit MB registers (MB0=MBP … MB7). On request, it replays a selected context into the MBU register file as a timed sequence of eight write cycles. While the sequence runs, it arbitrates the MBU write port against CPU OUT writes, and it snoops CPU writes to keep the active context's shadow coherent.

Parameters:
NCTX, 4, number of stored contexts (2..16); CW = clog2(NCTX)
TSU, 1, setup cycles with address/data stable before the strobe (≥1, covers the '670 setup time)
TW, 2, cycles mb_nw held low (≥1)

Ports:
clk  in  1  system clock; all state changes on rising edge
nreset  in  1  synchronous, active-low reset
req  in  1  start a context load; sampled only in IDLE
req_ctx  in  CW  context to load; captured with req
cpu_wen  in  1  CPU write to MB register (decoded IO &008–&00F with nW), one cycle per write
cpu_addr  in  3  AB[2:0] of the CPU write
cpu_data  in  8  DB[7:0] of the CPU write
cpu_wait  out  1  high while the sequencer owns the MBU write port
ctx_wen  in  1  host write into the shadow table
ctx_wsel  in  CW  shadow context to write
ctx_waddr  in  3  register index within that context
ctx_wdata  in  8  byte to store
mb_nw  out  1  active-low write strobe to the MBU
mb_addr  out  3  MB register index being written
mb_data  out  8  byte being written
cur_ctx  out  CW  context currently live in the MBU
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end

Behaviour:
- Reset (nreset=0 at an edge):
  - State IDLE; mb_nw=1; mb_addr=0; mb_data=0; busy=0; done=0; cpu_wait=0; cur_ctx=0.
  - All shadow bytes =0, except byte 7 of every context, which resets to &80 (ROM bank, matching the MBU power-on AEXT default).
- Reset mid-sequence aborts immediately: mb_nw=1 on the same edge, and no partial state is retained.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - On req=1, latch tgt=req_ctx, set idx=7, go to SETUP; busy=1 and cpu_wait=1 from the next cycle.
  - req in any other state is ignored; it is not queued.
- SETUP:
  - mb_addr=idx and mb_data=shadow[tgt][idx], registered; mb_nw=1.
  - Stay TSU cycles, then go to STROBE.
- STROBE: mb_nw=0 for exactly TW cycles; mb_addr/mb_data held. Then go to HOLD.
- HOLD: mb_nw=1 for 1 cycle, address/data held.
  - If idx=0, go to DONE.
  - Otherwise idx=idx−1 and go to SETUP.
- Write order is 7 down to 0, so MBP (index 0) is replaced last.
- Cycles per byte = TSU+TW+1. Total busy = 8·(TSU+TW+1)+1 cycles including DONE.
- DONE (1 cycle):
  - done=1, cur_ctx=tgt; busy and cpu_wait still 1.
  - Next state IDLE with busy=0, cpu_wait=0.
- mb_data is sampled from the shadow at SETUP entry. Host ctx_wen to the byte already emitted has no effect on the MBU; a write to a later byte is used.
- Shadow write priority (same edge, same byte): ctx_wen beats cpu snoop.
- CPU snoop:
  - In IDLE, cpu_wen=1 writes cpu_data into shadow[cur_ctx][cpu_addr]. The MBU itself performs that write; the sequencer does not drive mb_nw.
  - While busy, cpu_wen is ignored (not snooped). The CPU must stall on cpu_wait and retry.
  - cpu_wen coincident with req in IDLE: the snoop applies to the old cur_ctx, then the sequence starts.
- Loading cur_ctx onto itself is legal and performs the full sequence.
- mb_nw is glitch-free: registered, never low outside STROBE.

Test Plan:
- Reset, then req=1 req_ctx=0 (defaults TSU=1, TW=2):
  - mb_nw low for 2 cycles in each 4-cycle slot; addresses 7,6,…,0; data &80,0,…,0.
  - done pulses 33 cycles after req; cur_ctx=0.
- Host loads context 2 with bytes &10+i, then req_ctx=2:
  - Eight strobes carry (addr,data)=(7,&17)…(0,&10); cur_ctx=2 after done.
- In IDLE with cur_ctx=2, cpu_wen addr=3 data=&5A; then switch to ctx 1 and back to 2:
  - Final replay writes &5A at addr 3.
- cpu_wen and a second req asserted during a sequence:
  - cpu_wait=1 throughout; shadow unchanged; second req ignored; exactly 8 strobes.
- ctx_wen to tgt addr 0 while idx=5:
  - Addr 0 strobe carries the new byte.
  - Same test to addr 7 while idx=5: the old byte was already written, no extra strobe.
- nreset=0 during STROBE of addr 4:
  - mb_nw=1 next edge; busy=0; cur_ctx=0; shadow cleared (byte7=&80).

Source files
------------

// File: rtl/mbu_ctx_seq.sv
// Bank-map context sequencer: keeps NCTX shadow copies of the eight MB registers
// and replays a selected context into the MBU as eight timed write cycles (7 down to 0).
module mbu_ctx_seq #(
  parameter int NCTX = 4,
  parameter int TSU  = 1,
  parameter int TW   = 2,
  localparam int CW  = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          req,
  input  logic [CW-1:0] req_ctx,
  input  logic          cpu_wen,
  input  logic [2:0]    cpu_addr,
  input  logic [7:0]    cpu_data,
  output logic          cpu_wait,
  input  logic          ctx_wen,
  input  logic [CW-1:0] ctx_wsel,
  input  logic [2:0]    ctx_waddr,
  input  logic [7:0]    ctx_wdata,
  output logic          mb_nw,
  output logic [2:0]    mb_addr,
  output logic [7:0]    mb_data,
  output logic [CW-1:0] cur_ctx,
  output logic          busy,
  output logic          done
);

  localparam int MAXC = (TSU > TW) ? TSU : TW;
  localparam int CNTW = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic [CW-1:0] tgt_reg, tgt_next;
  logic [CW-1:0] cur_ctx_reg, cur_ctx_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic          mb_nw_reg, mb_nw_next;
  logic [2:0]    mb_addr_reg, mb_addr_next;
  logic [7:0]    mb_data_reg, mb_data_next;

  logic          snoop;
  logic [CW-1:0] rd_ctx;
  logic [2:0]    rd_idx;
  logic [7:0]    rd_byte;
  logic [7:0]    shadow [NCTX][8];

  assign snoop = cpu_wen && (state_reg == IDLE);

  // One register per shadow byte; host writes win over a same-byte CPU snoop.
  for (genvar gi = 0; gi < NCTX; gi++) begin : g_ctx
    for (genvar gj = 0; gj < 8; gj++) begin : g_byte
      logic [7:0] byte_reg;
      always_ff @(posedge clk) begin
        if (!nreset)
          byte_reg <= (gj == 7) ? 8'h80 : 8'h00;
        else if (ctx_wen && ctx_wsel == CW'(gi) && ctx_waddr == 3'(gj))
          byte_reg <= ctx_wdata;
        else if (snoop && cur_ctx_reg == CW'(gi) && cpu_addr == 3'(gj))
          byte_reg <= cpu_data;
      end
      assign shadow[gi][gj] = byte_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg   <= IDLE;
      idx_reg     <= 3'd0;
      tgt_reg     <= '0;
      cur_ctx_reg <= '0;
      cnt_reg     <= '0;
      mb_nw_reg   <= 1'b1;
      mb_addr_reg <= 3'd0;
      mb_data_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      tgt_reg     <= tgt_next;
      cur_ctx_reg <= cur_ctx_next;
      cnt_reg     <= cnt_next;
      mb_nw_reg   <= mb_nw_next;
      mb_addr_reg <= mb_addr_next;
      mb_data_reg <= mb_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    tgt_next     = tgt_reg;
    cur_ctx_next = cur_ctx_reg;
    cnt_next     = cnt_reg;
    mb_nw_next   = mb_nw_reg;
    mb_addr_next = mb_addr_reg;
    mb_data_next = mb_data_reg;

    // Byte captured on SETUP entry, bypassing writes landing on the same edge.
    rd_ctx = tgt_reg;
    rd_idx = idx_reg - 3'd1;
    if (state_reg == IDLE) begin
      rd_ctx = req_ctx;
      rd_idx = 3'd7;
    end
    rd_byte = shadow[rd_ctx][rd_idx];
    if (snoop && cur_ctx_reg == rd_ctx && cpu_addr == rd_idx)
      rd_byte = cpu_data;
    if (ctx_wen && ctx_wsel == rd_ctx && ctx_waddr == rd_idx)
      rd_byte = ctx_wdata;

    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next   = SETUP;
          tgt_next     = req_ctx;
          idx_next     = 3'd7;
          cnt_next     = '0;
          mb_addr_next = 3'd7;
          mb_data_next = rd_byte;
        end
      end
      SETUP: begin
        if (cnt_reg == CNTW'(TSU - 1)) begin
          state_next = STROBE;
          cnt_next   = '0;
          mb_nw_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNTW'(1);
        end
      end
      STROBE: begin
        if (cnt_reg == CNTW'(TW - 1)) begin
          state_next = HOLD;
          cnt_next   = '0;
          mb_nw_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNTW'(1);
        end
      end
      HOLD: begin
        if (idx_reg == 3'd0) begin
          state_next   = DONE;
          cur_ctx_next = tgt_reg;
        end else begin
          state_next   = SETUP;
          idx_next     = idx_reg - 3'd1;
          mb_addr_next = idx_reg - 3'd1;
          mb_data_next = rd_byte;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mb_nw    = mb_nw_reg;
  assign mb_addr  = mb_addr_reg;
  assign mb_data  = mb_data_reg;
  assign cur_ctx  = cur_ctx_reg;
  assign busy     = (state_reg != IDLE);
  assign cpu_wait = (state_reg != IDLE);
  assign done     = (state_reg == DONE);

endmodule
